// File: rtl/carrier_gen_if.sv
// Enable/config inputs and carrier outputs of carrier_gen.
// cfg_len and done exist only when CARRIER_BURST_EN is defined.
interface carrier_gen_if #(
  parameter int NCH = 4,
  parameter int FW  = 32,
  parameter int LW  = 16
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] en;
  logic           cfg_wr;
  logic [CW-1:0]  cfg_ch;
  logic [FW-1:0]  cfg_freq;
  logic [NCH-1:0] car_out;
`ifdef CARRIER_BURST_EN
  logic [LW-1:0]  cfg_len;
  logic [NCH-1:0] done;

  modport master (output en, cfg_wr, cfg_ch, cfg_freq, cfg_len, input car_out, done);
  modport slave  (input en, cfg_wr, cfg_ch, cfg_freq, cfg_len, output car_out, done);
`else
  modport master (output en, cfg_wr, cfg_ch, cfg_freq, input car_out);
  modport slave  (input en, cfg_wr, cfg_ch, cfg_freq, output car_out);
`endif

  if (NCH < 1 || NCH > 16 || LW < 1) begin : g_param_chk
    $error("carrier_gen_if: NCH must be 1..16 and LW >= 1");
  end
endinterface

// File: rtl/carrier_gen.sv
// Multi-channel square-wave carrier generator with fractional phase accumulators.
// Optional burst mode (N periods, then done pulse) is built when CARRIER_BURST_EN is defined.
module carrier_gen #(
  parameter int FCLK   = 50_000_000,
  parameter int NCH    = 4,
  parameter int FW     = 32,
  parameter int LW     = 16,
  parameter int FRESET = 38_000
) (
  input  logic         clk,
  input  logic         reset_n,
  carrier_gen_if.slave bus
);
  localparam int AW = FW + 2;
  localparam logic [AW-1:0] FCLK_A = AW'(FCLK);
  localparam logic [AW-1:0] HALF_A = AW'(FCLK / 2);

  if (NCH < 1 || NCH > 16 || LW < 1) begin : g_param_chk
    $error("carrier_gen: NCH must be 1..16 and LW >= 1");
  end

  logic [FW-1:0]  freq_q [NCH];
  logic [FW-1:0]  freq_d [NCH];
  logic [AW-1:0]  acc_q  [NCH];
  logic [AW-1:0]  acc_d  [NCH];
  logic [NCH-1:0] car_q, car_d;

  logic [AW-1:0]  fext_w [NCH];
  logic [AW-1:0]  step_w [NCH];
  logic [AW-1:0]  next_w [NCH];
  logic [NCH-1:0] wrap_w;
  logic [NCH-1:0] wr_sel_w;

`ifdef CARRIER_BURST_EN
  // state   | meaning
  // ST_IDLE | en low; burst length is latched on the first enabled cycle
  // ST_RUN  | burst (or continuous run) in progress
  // ST_HOLD | burst complete; output parked low until en falls
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} burst_st_e;

  burst_st_e      st_q   [NCH];
  burst_st_e      st_d   [NCH];
  logic [LW-1:0]  len_q  [NCH];
  logic [LW-1:0]  len_d  [NCH];
  logic [LW-1:0]  blen_q [NCH];
  logic [LW-1:0]  blen_d [NCH];
  logic [LW:0]    cnt_q  [NCH];
  logic [LW:0]    cnt_d  [NCH];
  logic [LW-1:0]  eff_len_w [NCH];
  logic [NCH-1:0] done_q, done_d;
`endif

  // Step is clamped to FCLK so a wrap happens at most once per cycle.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      fext_w[i]   = AW'(freq_q[i]);
      step_w[i]   = ((fext_w[i] > HALF_A) ? HALF_A : fext_w[i]) << 1;
      next_w[i]   = acc_q[i] + step_w[i];
      wrap_w[i]   = (next_w[i] >= FCLK_A);
      wr_sel_w[i] = bus.cfg_wr && (int'(bus.cfg_ch) == i);
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      freq_d[i] = wr_sel_w[i] ? bus.cfg_freq : freq_q[i];
      acc_d[i]  = acc_q[i];
      car_d[i]  = car_q[i];
`ifdef CARRIER_BURST_EN
      len_d[i]     = wr_sel_w[i] ? bus.cfg_len : len_q[i];
      blen_d[i]    = blen_q[i];
      cnt_d[i]     = cnt_q[i];
      st_d[i]      = st_q[i];
      done_d[i]    = 1'b0;
      eff_len_w[i] = (st_q[i] == ST_IDLE) ? len_q[i] : blen_q[i];
`endif
      if (!bus.en[i]) begin
        acc_d[i] = '0;
        car_d[i] = 1'b0;
`ifdef CARRIER_BURST_EN
        cnt_d[i] = '0;
        st_d[i]  = ST_IDLE;
      end else if (st_q[i] == ST_HOLD) begin
        acc_d[i] = '0;
        car_d[i] = 1'b0;
`endif
      end else if (wrap_w[i]) begin
        acc_d[i] = next_w[i] - FCLK_A;
        car_d[i] = ~car_q[i];
      end else begin
        acc_d[i] = next_w[i];
      end
`ifdef CARRIER_BURST_EN
      // Count toggles; the 2N-th one is the falling edge that ends the burst.
      if (bus.en[i] && (st_q[i] != ST_HOLD)) begin
        st_d[i]   = ST_RUN;
        blen_d[i] = eff_len_w[i];
        if (wrap_w[i] && (eff_len_w[i] != '0)) begin
          if ((cnt_q[i] + 1'b1) == {eff_len_w[i], 1'b0}) begin
            done_d[i] = 1'b1;
            st_d[i]   = ST_HOLD;
            cnt_d[i]  = '0;
            acc_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        freq_q[i] <= FW'(FRESET);
        acc_q[i]  <= '0;
`ifdef CARRIER_BURST_EN
        len_q[i]  <= '0;
        blen_q[i] <= '0;
        cnt_q[i]  <= '0;
        st_q[i]   <= ST_IDLE;
`endif
      end
      car_q <= '0;
`ifdef CARRIER_BURST_EN
      done_q <= '0;
`endif
    end else begin
      for (int i = 0; i < NCH; i++) begin
        freq_q[i] <= freq_d[i];
        acc_q[i]  <= acc_d[i];
`ifdef CARRIER_BURST_EN
        len_q[i]  <= len_d[i];
        blen_q[i] <= blen_d[i];
        cnt_q[i]  <= cnt_d[i];
        st_q[i]   <= st_d[i];
`endif
      end
      car_q <= car_d;
`ifdef CARRIER_BURST_EN
      done_q <= done_d;
`endif
    end
  end

  assign bus.car_out = car_q;
`ifdef CARRIER_BURST_EN
  assign bus.done = done_q;
`endif
endmodule

// File: tb/tb_carrier_gen.sv
// Randomized + directed bench for carrier_gen, checked against a cycle-level model of the
// carrier rules. Burst tests are built when CARRIER_BURST_EN is defined.
module tb_carrier_gen;
  localparam int FCLK   = 100;
  localparam int NCH    = 4;
  localparam int FW     = 32;
  localparam int LW     = 16;
  localparam int FRESET = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  carrier_gen_if #(.NCH(NCH), .FW(FW), .LW(LW)) bus ();

  carrier_gen #(
    .FCLK(FCLK), .NCH(NCH), .FW(FW), .LW(LW), .FRESET(FRESET)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: phase as a plain integer, burst as toggles remaining.
  int m_freq [NCH];
  int m_acc  [NCH];
  bit m_car  [NCH];
  int m_len  [NCH];
  int m_left [NCH];
  bit m_active [NCH];
  bit m_finished [NCH];
  bit m_done [NCH];

  function automatic void model_update();
    int s;
    int n;
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_freq[c] = FRESET; m_acc[c] = 0; m_car[c] = 0; m_len[c] = 0;
        m_left[c] = 0; m_active[c] = 0; m_finished[c] = 0; m_done[c] = 0;
      end
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      m_done[c] = 0;
      if (!bus.en[c]) begin
        m_acc[c] = 0; m_car[c] = 0; m_active[c] = 0; m_finished[c] = 0;
      end else if (m_finished[c]) begin
        m_acc[c] = 0; m_car[c] = 0;
      end else begin
        if (!m_active[c]) begin
          m_active[c] = 1;
          m_left[c] = 2 * m_len[c];
        end
        s = 2 * ((m_freq[c] > FCLK / 2) ? FCLK / 2 : m_freq[c]);
        n = m_acc[c] + s;
        if (n >= FCLK) begin
          m_acc[c] = n - FCLK;
          m_car[c] = ~m_car[c];
          if (m_left[c] > 0) begin
            m_left[c]--;
            if (m_left[c] == 0) begin
              m_done[c] = 1; m_finished[c] = 1; m_acc[c] = 0;
            end
          end
        end else begin
          m_acc[c] = n;
        end
      end
    end
    if (bus.cfg_wr && int'(bus.cfg_ch) < NCH) begin
      m_freq[bus.cfg_ch] = int'(bus.cfg_freq);
`ifdef CARRIER_BURST_EN
      m_len[bus.cfg_ch] = int'(bus.cfg_len);
`endif
    end
  endfunction

  function automatic logic [NCH-1:0] model_car();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_car[c];
    return v;
  endfunction

  function automatic logic [NCH-1:0] model_done();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_done[c];
    return v;
  endfunction

  task automatic step_clk();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cfg_write(input int ch, input int freq, input int len);
    bus.cfg_wr = 1'b1;
    bus.cfg_ch = 2'(ch);
    bus.cfg_freq = 32'(freq);
`ifdef CARRIER_BURST_EN
    bus.cfg_len = 16'(len);
`else
    if (len != 0) $display("note: burst length ignored in continuous build");
`endif
    step_clk();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.en = '0; bus.cfg_wr = 1'b0; bus.cfg_ch = '0; bus.cfg_freq = '0;
`ifdef CARRIER_BURST_EN
    bus.cfg_len = '0;
`endif
    repeat (3) step_clk();
    checks++;
    if (bus.car_out !== 4'b0000) begin
      failures++; $display("FAIL reset_car_out actual=%b required=0000", bus.car_out);
    end
`ifdef CARRIER_BURST_EN
    checks++;
    if (bus.done !== 4'b0000) begin
      failures++; $display("FAIL reset_done actual=%b required=0000", bus.done);
    end
`endif
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step_clk();
      checks++;
      if (bus.car_out !== 4'b0000) begin
        failures++; $display("FAIL idle_no_toggle cycle=%0d actual=%b required=0000", k, bus.car_out);
      end
    end
  endtask

  task automatic test_reset_freq();
    // FRESET=20: acc 40, 80, 120->20 toggles at the third edge.
    logic exp_seq [3];
    exp_seq = '{1'b0, 1'b0, 1'b1};
    bus.en[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step_clk();
      checks++;
      if (bus.car_out[0] !== exp_seq[k]) begin
        failures++; $display("FAIL freset_first_toggle edge=%0d actual=%b required=%b", k + 1, bus.car_out[0], exp_seq[k]);
      end
    end
    for (int k = 0; k < 30; k++) begin
      step_clk();
      checks++;
      if (bus.car_out !== model_car()) begin
        failures++; $display("FAIL freset_run cycle=%0d actual=%b required=%b", k, bus.car_out, model_car());
      end
    end
    bus.en[0] = 1'b0;
    step_clk();
  endtask

  task automatic test_ch0_25();
    int highs;
    int rises;
    logic prev;
    cfg_write(0, 25, 0);
    bus.en[0] = 1'b1;
    step_clk();
    checks++;
    if (bus.car_out[0] !== 1'b0) begin
      failures++; $display("FAIL ch0_edge1 actual=%b required=0", bus.car_out[0]);
    end
    step_clk();
    checks++;
    if (bus.car_out[0] !== 1'b1) begin
      failures++; $display("FAIL ch0_edge2 actual=%b required=1", bus.car_out[0]);
    end
    highs = 0; rises = 0; prev = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step_clk();
      if (bus.car_out[0] === 1'b1) highs++;
      if (bus.car_out[0] === 1'b1 && prev === 1'b0) rises++;
      prev = bus.car_out[0];
    end
    checks++;
    if (highs != 50) begin
      failures++; $display("FAIL ch0_duty actual=%0d required=50", highs);
    end
    checks++;
    if (rises != 25) begin
      failures++; $display("FAIL ch0_periods actual=%0d required=25", rises);
    end
    bus.en[0] = 1'b0;
    step_clk();
  endtask

  task automatic test_ch1_30();
    logic exp_seq [5];
    int togs;
    logic prev;
    exp_seq = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    cfg_write(1, 30, 0);
    bus.en[1] = 1'b1;
    togs = 0; prev = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      step_clk();
      if (bus.car_out[1] !== prev) togs++;
      prev = bus.car_out[1];
      if (k < 5) begin
        checks++;
        if (bus.car_out[1] !== exp_seq[k]) begin
          failures++; $display("FAIL ch1_pattern edge=%0d actual=%b required=%b", k + 1, bus.car_out[1], exp_seq[k]);
        end
      end
      if (k == 99) begin
        checks++;
        if (togs != 60) begin
          failures++; $display("FAIL ch1_toggles_100 actual=%0d required=60", togs);
        end
      end
      if (k % 50 == 7) begin
        checks++;
        if (bus.car_out !== model_car()) begin
          failures++; $display("FAIL ch1_model cycle=%0d actual=%b required=%b", k, bus.car_out, model_car());
        end
      end
    end
    checks++;
    if (togs != 600) begin
      failures++; $display("FAIL ch1_toggles_1000 actual=%0d required=600", togs);
    end
    bus.en[1] = 1'b0;
    step_clk();
  endtask

  task automatic test_clamp();
    cfg_write(2, 60, 0);
    bus.en[2] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step_clk();
      checks++;
      if (bus.car_out[2] !== 1'(k % 2)) begin
        failures++; $display("FAIL clamp_toggle edge=%0d actual=%b required=%b", k, bus.car_out[2], 1'(k % 2));
      end
    end
    cfg_write(2, 0, 0);
    checks++;
    if (bus.car_out[2] !== 1'b1) begin
      failures++; $display("FAIL clamp_old_freq_on_write actual=%b required=1", bus.car_out[2]);
    end
    for (int k = 0; k < 10; k++) begin
      step_clk();
      checks++;
      if (bus.car_out[2] !== 1'b1) begin
        failures++; $display("FAIL freq0_freeze cycle=%0d actual=%b required=1", k, bus.car_out[2]);
      end
    end
    bus.en[2] = 1'b0;
    step_clk();
    checks++;
    if (bus.car_out[2] !== 1'b0) begin
      failures++; $display("FAIL disable_clear actual=%b required=0", bus.car_out[2]);
    end
  endtask

  task automatic test_wr_on_disable();
    logic exp_seq [3];
    exp_seq = '{1'b1, 1'b0, 1'b1};
    bus.en[1] = 1'b1;
    repeat (7) step_clk();
    bus.en[1] = 1'b0;
    cfg_write(1, 50, 0);
    checks++;
    if (bus.car_out[1] !== 1'b0) begin
      failures++; $display("FAIL wr_on_disable_clear actual=%b required=0", bus.car_out[1]);
    end
    bus.en[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step_clk();
      checks++;
      if (bus.car_out[1] !== exp_seq[k]) begin
        failures++; $display("FAIL wr_on_disable_stored edge=%0d actual=%b required=%b", k + 1, bus.car_out[1], exp_seq[k]);
      end
    end
    bus.en[1] = 1'b0;
    step_clk();
  endtask

  task automatic test_retune();
    int last;
    int r;
    logic prev;
    bus.en[0] = 1'b1;
    r = $urandom_range(4, 20);
    for (int k = 0; k < r; k++) step_clk();
    cfg_write(0, 10, 0);
    last = -1; prev = bus.car_out[0];
    for (int k = 0; k < 80; k++) begin
      step_clk();
      checks++;
      if (bus.car_out !== model_car()) begin
        failures++; $display("FAIL retune_model cycle=%0d actual=%b required=%b", k, bus.car_out, model_car());
      end
      if (bus.car_out[0] !== prev && k >= 40) begin
        if (last >= 0) begin
          checks++;
          if (k - last != 5) begin
            failures++; $display("FAIL retune_half_period actual=%0d required=5", k - last);
          end
        end
        last = k;
      end
      prev = bus.car_out[0];
    end
    bus.en[0] = 1'b0;
    step_clk();
  endtask

  task automatic test_random();
    int c;
    bus.en = '0;
    step_clk();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        c = $urandom_range(0, NCH - 1);
        bus.en[c] = ~bus.en[c];
      end
      bus.cfg_wr = ($urandom_range(0, 5) == 0);
      bus.cfg_ch = 2'($urandom_range(0, NCH - 1));
      bus.cfg_freq = 32'($urandom_range(0, 70));
`ifdef CARRIER_BURST_EN
      bus.cfg_len = 16'($urandom_range(0, 4));
`endif
      step_clk();
      checks++;
      if (bus.car_out !== model_car()) begin
        failures++; $display("FAIL random_car cycle=%0d actual=%b required=%b", n, bus.car_out, model_car());
      end
`ifdef CARRIER_BURST_EN
      checks++;
      if (bus.done !== model_done()) begin
        failures++; $display("FAIL random_done cycle=%0d actual=%b required=%b", n, bus.done, model_done());
      end
`endif
    end
    bus.cfg_wr = 1'b0;
    bus.en = '0;
    step_clk();
  endtask

`ifdef CARRIER_BURST_EN
  task automatic test_burst();
    int togs;
    logic prev;
    cfg_write(3, 25, 3);
    bus.en[3] = 1'b1;
    togs = 0; prev = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step_clk();
      if (bus.car_out[3] !== prev) togs++;
      prev = bus.car_out[3];
      checks++;
      if (bus.done[3] !== (k == 12)) begin
        failures++; $display("FAIL burst_done edge=%0d actual=%b required=%b", k, bus.done[3], (k == 12));
      end
    end
    checks++;
    if (togs != 6) begin
      failures++; $display("FAIL burst_toggles actual=%0d required=6", togs);
    end
    checks++;
    if (bus.car_out[3] !== 1'b0) begin
      failures++; $display("FAIL burst_end_low actual=%b required=0", bus.car_out[3]);
    end
    for (int k = 0; k < 20; k++) begin
      step_clk();
      checks++;
      if (bus.car_out[3] !== 1'b0 || bus.done[3] !== 1'b0) begin
        failures++; $display("FAIL burst_idle cycle=%0d actual=%b%b required=00", k, bus.car_out[3], bus.done[3]);
      end
    end
    // Rerun with len=3 latched; a len=1 write mid-burst applies only to the next burst.
    bus.en[3] = 1'b0;
    step_clk();
    bus.en[3] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) cfg_write(3, 25, 1);
      else step_clk();
      checks++;
      if (bus.done[3] !== 1'b0) begin
        failures++; $display("FAIL rerun_early_done edge=%0d actual=%b required=0", k, bus.done[3]);
      end
    end
    bus.en[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step_clk();
      checks++;
      if (bus.done[3] !== 1'b0 || bus.car_out[3] !== 1'b0) begin
        failures++; $display("FAIL abort_no_done cycle=%0d actual=%b%b required=00", k, bus.car_out[3], bus.done[3]);
      end
    end
    bus.en[3] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step_clk();
      checks++;
      if (bus.done[3] !== (k == 4)) begin
        failures++; $display("FAIL len1_done edge=%0d actual=%b required=%b", k, bus.done[3], (k == 4));
      end
    end
    bus.en[3] = 1'b0;
    step_clk();
  endtask
`endif

  initial begin
    test_reset();
    test_reset_freq();
    test_ch0_25();
    test_ch1_30();
    test_clamp();
    test_wr_on_disable();
    test_retune();
`ifdef CARRIER_BURST_EN
    test_burst();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
